// File: rtl/program_sequencer_if.sv
// Host/debug port and decoder-facing signals of the program sequencer.
// The sequencer uses the slave modport; the host/debug side uses master.
interface program_sequencer_if;
  logic        cmd_start;
  logic        cmd_stop;
  logic        cmd_step;
  logic        loop_en;
  logic [3:0]  prog_last;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [10:0] host_wdata;
  logic        host_pc_we;
  logic [3:0]  host_pc;
  logic [10:0] instruction;
  logic [3:0]  pc;
  logic [1:0]  phase;
  logic        running;
  logic        retire;
  logic        done;
  logic        load_err;

  modport slave (
    input  cmd_start, cmd_stop, cmd_step, loop_en, prog_last,
           host_we, host_addr, host_wdata, host_pc_we, host_pc,
    output instruction, pc, phase, running, retire, done, load_err
  );

  modport master (
    output cmd_start, cmd_stop, cmd_step, loop_en, prog_last,
           host_we, host_addr, host_wdata, host_pc_we, host_pc,
    input  instruction, pc, phase, running, retire, done, load_err
  );
endinterface

// File: rtl/program_sequencer.sv
// Instruction-issue controller: program store, PC and run/step/halt control,
// presenting one instruction per decoder FETCH/EXEC/STORE cycle.
module program_sequencer #(
  parameter logic [10:0] NOP_INSTR  = 11'h700,
  parameter int          PROG_DEPTH = 16
) (
  input logic               clk,
  input logic               reset,
  program_sequencer_if.slave bus
);

  typedef enum logic [1:0] {HALT, RUN, STEP_WAIT, STEP_EXEC} state_t;

  state_t      state;
  state_t      st_cmd;
  state_t      st_mid;
  state_t      st_bnd;
  logic [10:0] mem [PROG_DEPTH];
  logic [10:0] instr_q;
  logic [3:0]  pc_q;
  logic [3:0]  pc_cur;
  logic [3:0]  pc_ret;
  logic [1:0]  phase;
  logic        issued;
  logic        stop_pend;
  logic        pend_cmd;
  logic        boundary;
  logic        host_ok;
  logic        start_ok;
  logic        step_ok;
  logic        last_hit;
  logic        halt_now;
  logic        issue_now;
  logic        done_q;
  logic        load_err_q;

  // Decoder slots change hands on the INIT edge and on every STORE edge.
  assign boundary = (phase == 2'd0) || (phase == 2'd3);
  assign host_ok  = (state == HALT) && !issued;
  assign start_ok = (state == HALT) && bus.cmd_start && !bus.cmd_stop;
  assign step_ok  = (state == HALT) && bus.cmd_step && !bus.cmd_start && !bus.cmd_stop;
  assign pend_cmd = stop_pend || (bus.cmd_stop && (state != HALT));

  // A host PC load is folded in before retirement so start+load issues from the new PC.
  assign pc_cur   = (bus.host_pc_we && host_ok) ? bus.host_pc : pc_q;
  assign last_hit = issued && (pc_cur == bus.prog_last);
  assign pc_ret   = !issued ? pc_cur :
                    (pc_cur == bus.prog_last) ? 4'd0 : pc_cur + 4'd1;

  always_comb begin
    st_cmd = state;
    if (start_ok)
      st_cmd = RUN;
    else if (step_ok)
      st_cmd = STEP_WAIT;
  end

  assign halt_now  = pend_cmd || (last_hit && !bus.loop_en) ||
                     (issued && (st_cmd == STEP_EXEC));
  assign issue_now = !halt_now && ((st_cmd == RUN) || (st_cmd == STEP_WAIT));

  always_comb begin
    st_mid = halt_now ? HALT : st_cmd;
    st_bnd = (st_mid == STEP_WAIT) ? STEP_EXEC : st_mid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 2'd0;
      state      <= HALT;
      stop_pend  <= 1'b0;
      issued     <= 1'b0;
      pc_q       <= 4'd0;
      instr_q    <= NOP_INSTR;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      for (int i = 0; i < PROG_DEPTH; i++)
        mem[i] <= NOP_INSTR;
    end else begin
      phase      <= (phase == 2'd3) ? 2'd1 : phase + 2'd1;
      done_q     <= boundary && last_hit && !bus.loop_en;
      load_err_q <= (bus.host_we || bus.host_pc_we) && !host_ok;
      if (bus.host_we && host_ok)
        mem[bus.host_addr] <= bus.host_wdata;
      if (boundary) begin
        state     <= st_bnd;
        stop_pend <= 1'b0;
        pc_q      <= pc_ret;
        issued    <= issue_now;
        instr_q   <= issue_now ? mem[pc_ret] : NOP_INSTR;
      end else begin
        state     <= st_cmd;
        stop_pend <= pend_cmd;
        pc_q      <= pc_cur;
      end
    end
  end

  assign bus.instruction = instr_q;
  assign bus.pc          = pc_q;
  assign bus.phase       = phase;
  assign bus.running     = (state != HALT);
  assign bus.retire      = (phase == 2'd3) && issued;
  assign bus.done        = done_q;
  assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer: reset, run, loop,
// step, mid-run stop, rejected writes, command collisions and reset mid-run.
module tb_program_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic [10:0] prog [3];

  program_sequencer_if bus ();

  program_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_store();
    for (int i = 0; i < 4 && bus.phase != 2'd3; i++)
      applyStimulus(1);
    checkOutput("phase_sync", 32'(bus.phase), 32'd3);
  endtask

  // Assumes cmd_start was just set on a STORE cycle; checks three 3-cycle slots.
  task automatic check_three_slots(input string tag);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        applyStimulus(1);
        bus.cmd_start = 1'b0;
        checkOutput({tag, "_instr"}, 32'(bus.instruction), 32'(prog[k]));
        checkOutput({tag, "_phase"}, 32'(bus.phase), 32'(c + 1));
        checkOutput({tag, "_retire"}, 32'(bus.retire), 32'(c == 2));
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
      end
    end
  endtask

  task automatic do_step(input string tag, input logic [10:0] word,
                         input logic [3:0] pc_after);
    int  retires;
    logic seen;
    bus.cmd_step = 1'b1;
    applyStimulus(1);
    bus.cmd_step = 1'b0;
    retires = 0;
    seen    = (bus.instruction == word);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      if (bus.retire) retires++;
      if (bus.instruction == word) seen = 1'b1;
    end
    checkOutput({tag, "_retires"}, 32'(retires), 32'd1);
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_pc"}, 32'(bus.pc), 32'(pc_after));
    checkOutput({tag, "_running"}, 32'(bus.running), 32'd0);
    checkOutput({tag, "_nop"}, 32'(bus.instruction), 32'h700);
  endtask

  initial begin
    prog[0] = 11'h012;
    prog[1] = 11'h123;
    prog[2] = 11'h234;
    reset          = 1'b1;
    bus.cmd_start  = 1'b0;
    bus.cmd_stop   = 1'b0;
    bus.cmd_step   = 1'b0;
    bus.loop_en    = 1'b0;
    bus.prog_last  = 4'd2;
    bus.host_we    = 1'b0;
    bus.host_addr  = 4'd0;
    bus.host_wdata = 11'h0;
    bus.host_pc_we = 1'b0;
    bus.host_pc    = 4'd0;

    // Reset values and phase sequence after release
    applyStimulus(2);
    checkOutput("rst_instr", 32'(bus.instruction), 32'h700);
    checkOutput("rst_pc", 32'(bus.pc), 32'd0);
    checkOutput("rst_phase", 32'(bus.phase), 32'd0);
    checkOutput("rst_running", 32'(bus.running), 32'd0);
    checkOutput("rst_retire", 32'(bus.retire), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_load_err", 32'(bus.load_err), 32'd0);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("phase_a", 32'(bus.phase), 32'd1);
    applyStimulus(1);
    checkOutput("phase_b", 32'(bus.phase), 32'd2);
    applyStimulus(1);
    checkOutput("phase_c", 32'(bus.phase), 32'd3);
    applyStimulus(1);
    checkOutput("phase_d", 32'(bus.phase), 32'd1);
    checkOutput("idle_instr", 32'(bus.instruction), 32'h700);

    // Program load while halted
    for (int a = 0; a < 3; a++) begin
      bus.host_we    = 1'b1;
      bus.host_addr  = 4'(a);
      bus.host_wdata = prog[a];
      applyStimulus(1);
      bus.host_we = 1'b0;
      checkOutput("load_ok", 32'(bus.load_err), 32'd0);
    end

    // Single run, no loop
    wait_store();
    bus.cmd_start = 1'b1;
    check_three_slots("run");
    applyStimulus(1);
    checkOutput("run_end_instr", 32'(bus.instruction), 32'h700);
    checkOutput("run_end_done", 32'(bus.done), 32'd1);
    checkOutput("run_end_pc", 32'(bus.pc), 32'd0);
    checkOutput("run_end_running", 32'(bus.running), 32'd0);
    applyStimulus(1);
    checkOutput("run_done_pulse", 32'(bus.done), 32'd0);

    // Looping run, rejected write, then stop
    bus.loop_en = 1'b1;
    wait_store();
    bus.cmd_start = 1'b1;
    check_three_slots("loop");
    applyStimulus(1);
    checkOutput("loop_wrap_instr", 32'(bus.instruction), 32'h012);
    checkOutput("loop_wrap_pc", 32'(bus.pc), 32'd0);
    checkOutput("loop_wrap_done", 32'(bus.done), 32'd0);
    bus.host_we    = 1'b1;
    bus.host_addr  = 4'd1;
    bus.host_wdata = 11'h7FF;
    applyStimulus(1);
    bus.host_we = 1'b0;
    checkOutput("rej_load_err", 32'(bus.load_err), 32'd1);
    bus.cmd_stop = 1'b1;
    applyStimulus(1);
    bus.cmd_stop = 1'b0;
    checkOutput("rej_load_err_pulse", 32'(bus.load_err), 32'd0);
    checkOutput("loop_stop_retire", 32'(bus.retire), 32'd1);
    applyStimulus(1);
    checkOutput("loop_stop_instr", 32'(bus.instruction), 32'h700);
    checkOutput("loop_stop_pc", 32'(bus.pc), 32'd1);
    checkOutput("loop_stop_running", 32'(bus.running), 32'd0);
    checkOutput("loop_stop_done", 32'(bus.done), 32'd0);

    // Single steps from pc 0; the second also shows entry 1 survived the rejected write
    bus.loop_en    = 1'b0;
    bus.host_pc_we = 1'b1;
    bus.host_pc    = 4'd0;
    applyStimulus(1);
    bus.host_pc_we = 1'b0;
    checkOutput("pcload_pc", 32'(bus.pc), 32'd0);
    checkOutput("pcload_err", 32'(bus.load_err), 32'd0);
    do_step("step1", 11'h012, 4'd1);
    do_step("step2", 11'h123, 4'd2);

    // Stop during EXEC of pc 1
    bus.host_pc_we = 1'b1;
    bus.host_pc    = 4'd0;
    applyStimulus(1);
    bus.host_pc_we = 1'b0;
    wait_store();
    bus.cmd_start = 1'b1;
    applyStimulus(1);
    bus.cmd_start = 1'b0;
    applyStimulus(3);
    checkOutput("mid_pc1_instr", 32'(bus.instruction), 32'h123);
    applyStimulus(1);
    checkOutput("mid_exec_pc", 32'(bus.pc), 32'd1);
    checkOutput("mid_exec_phase", 32'(bus.phase), 32'd2);
    bus.cmd_stop = 1'b1;
    applyStimulus(1);
    bus.cmd_stop = 1'b0;
    checkOutput("mid_retire", 32'(bus.retire), 32'd1);
    applyStimulus(1);
    checkOutput("mid_pc", 32'(bus.pc), 32'd2);
    checkOutput("mid_running", 32'(bus.running), 32'd0);
    checkOutput("mid_instr", 32'(bus.instruction), 32'h700);

    // Start and stop together while halted
    bus.cmd_start = 1'b1;
    bus.cmd_stop  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("coll_running", 32'(bus.running), 32'd0);
      checkOutput("coll_instr", 32'(bus.instruction), 32'h700);
    end
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("coll_after_instr", 32'(bus.instruction), 32'h700);
      checkOutput("coll_after_retire", 32'(bus.retire), 32'd0);
    end

    // PC load and start on the same edge, then reset mid-run
    wait_store();
    bus.host_pc_we = 1'b1;
    bus.host_pc    = 4'd1;
    bus.cmd_start  = 1'b1;
    applyStimulus(1);
    bus.host_pc_we = 1'b0;
    bus.cmd_start  = 1'b0;
    checkOutput("ldstart_instr", 32'(bus.instruction), 32'h123);
    checkOutput("ldstart_pc", 32'(bus.pc), 32'd1);
    checkOutput("ldstart_running", 32'(bus.running), 32'd1);
    applyStimulus(1);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midrst_instr", 32'(bus.instruction), 32'h700);
    checkOutput("midrst_pc", 32'(bus.pc), 32'd0);
    checkOutput("midrst_phase", 32'(bus.phase), 32'd0);
    checkOutput("midrst_running", 32'(bus.running), 32'd0);
    checkOutput("midrst_retire", 32'(bus.retire), 32'd0);
    reset         = 1'b0;
    bus.cmd_start = 1'b1;
    applyStimulus(1);
    bus.cmd_start = 1'b0;
    checkOutput("cleared_instr", 32'(bus.instruction), 32'h700);
    checkOutput("cleared_running", 32'(bus.running), 32'd1);
    checkOutput("cleared_phase", 32'(bus.phase), 32'd1);
    checkOutput("cleared_pc", 32'(bus.pc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction-issue controller for the 4-bit CPU. It owns a 16 x 11-bit program store, a program counter and run/step/halt control. It presents one instruction to the instruction decoder per decoder cycle (FETCH/EXEC/STORE), holding each instruction stable for the whole cycle. It sits between the host/debug port and the decoder's `instruction` input, and tracks the decoder's phase with a mirror counter.

## Interface
Parameters:
- `NOP_INSTR`, 11'h700: instruction driven when no program slot is issued. The opcode decodes to ALU transfer, so STORE writes back RAM[0] unchanged.
- `PROG_DEPTH`, 16: program store entries; the PC is 4 bits.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high. The top level drives the decoder with `reset_n = ~reset`, so both leave reset on the same edge.
- `cmd_start`  in  1  pulse: begin continuous run from `pc`.
- `cmd_stop`  in  1  pulse: halt after the in-flight instruction retires.
- `cmd_step`  in  1  pulse: issue exactly one instruction from `pc`.
- `loop_en`  in  1  1 = wrap to 0 after `prog_last`; 0 = halt there.
- `prog_last`  in  4  address of the last program instruction.
- `host_we`  in  1  write `host_wdata` to program store entry `host_addr`.
- `host_addr`  in  4  program store write address.
- `host_wdata`  in  11  instruction word: [10:8] opcode, [7:4] op1, [3:0] op2.
- `host_pc_we`  in  1  load `pc` from `host_pc`.
- `host_pc`  in  4  PC load value.
- `instruction`  out  11  registered; drives the decoder.
- `pc`  out  4  address of the next or in-flight instruction.
- `phase`  out  2  mirror of decoder state: 0 INIT, 1 FETCH, 2 EXEC, 3 STORE.
- `running`  out  1  high in any state other than HALT.
- `retire`  out  1  high during the STORE cycle of a real (non-NOP) slot.
- `done`  out  1  one-cycle pulse after halting at `prog_last`.
- `load_err`  out  1  one-cycle pulse when a host write is rejected.

## Operation
- **Phase mirror:**
  - INIT lasts 1 cycle after reset.
  - Then the sequence is FETCH→EXEC→STORE→FETCH….
  - A boundary edge is a clock edge where `phase` is INIT or STORE.
- **States:** HALT, RUN, STEP_WAIT (step requested, not issued), STEP_EXEC (step slot in flight).
- **Commands** are sampled every cycle:
  - HALT + `cmd_start` → RUN.
  - HALT + `cmd_step` → STEP_WAIT.
  - RUN, STEP_WAIT or STEP_EXEC + `cmd_stop` → sets `stop_pend`.
  - Start+stop in the same cycle: stop wins, state stays HALT.
  - Start+step in the same cycle: start wins.
  - Start or step outside HALT: ignored.
- **At each boundary edge, in order:**
  1. If the current slot is real (`issued`=1), it retires.
     - `pc` ← `pc`==`prog_last` ? 0 : `pc`+1.
     - If `pc` was `prog_last` and `loop_en`=0: state → HALT, `done` fires next cycle.
     - STEP_EXEC → HALT.
  2. If `stop_pend` is set: state → HALT and `stop_pend` is cleared.
  3. Next slot:
     - State RUN: `instruction` ← mem[`pc`] (post-update), `issued` ← 1.
     - State STEP_WAIT: the same issue, and state → STEP_EXEC.
     - Otherwise: `instruction` ← `NOP_INSTR`, `issued` ← 0.
- **Host writes:**
  - Accepted only when state=HALT and `issued`=0.
  - A rejected `host_we` or `host_pc_we` leaves store and `pc` unchanged and pulses `load_err` the next cycle.
  - `host_pc_we` and an accepted `cmd_start` in the same cycle: the PC load applies first.
- **PC wrap:** values above `prog_last` (from `host_pc`) advance normally up to 15, then wrap to 0.

## Timing
- **Reset values:**
  - `instruction`=`NOP_INSTR`, `pc`=0, `phase`=0, state HALT, `issued`=0.
  - `retire`=0, `done`=0, `load_err`=0, `running`=0.
  - All store entries = `NOP_INSTR`.
- **Instruction timing:**
  - `instruction` changes only on boundary edges and is stable across FETCH/EXEC/STORE.
  - One instruction per 3 cycles in RUN.
- **Start latency:** `cmd_start` to first real FETCH is 1–3 cycles, waiting for the next boundary.
- **Outputs:**
  - `retire` is decoded from `phase`/`issued` registers, with no extra delay.
  - `done` and `load_err` are registered 1-cycle pulses.
- **Reset mid-run:** the in-flight instruction is discarded without retiring. The store is cleared and `phase` restarts at INIT.

## Test plan
- **Reset:**
  - Assert `reset` 2 cycles → `instruction`=11'h700, `pc`=0, `phase`=0.
  - After release: `phase` is 1,2,3,1 on successive cycles.
- **Single run:**
  - Load 11'h012, 11'h123, 11'h234 at 0–2; `prog_last`=2, `loop_en`=0; `cmd_start`.
  - → Each word is held for 3 cycles in order, with 3 `retire` pulses.
  - → `done` pulse, `pc`=0, `running`=0, then `instruction`=11'h700.
- **Loop:** same program with `loop_en`=1 → after address 2, address 0 is reissued and `done` never fires. Then `cmd_stop` → halts after the current retire.
- **Step:**
  - `cmd_step` twice, 10 cycles apart → exactly one real slot each.
  - → `pc` goes 0→1→2, with NOP slots in between.
- **Mid-run stop:** `cmd_stop` during EXEC of `pc`=1 → `pc`=1 still retires, `pc`=2, state HALT, next slot is NOP.
- **Rejected writes and command collision:**
  - `host_we` while running → store unchanged, `load_err`=1 for 1 cycle.
  - `cmd_start`+`cmd_stop` in the same cycle while halted → stays HALT, no real slot is issued.
